// File: rtl/vo_src_sched.sv
// Video output source scheduler: picks pattern or framebuffer pixels per frame,
// substitutes a fixed colour on FIFO underflow and tracks underflow statistics.
module vo_src_sched #(
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF,
    parameter int          CNT_W           = 8
) (
    input  logic             vo_clk,
    input  logic             vo_reset_,
    input  logic             in_vsync,
    input  logic             in_req,
    input  logic             in_eol,
    input  logic             in_eof,
    input  logic [23:0]      in_pixel,
    input  logic             fb_valid,
    input  logic [23:0]      fb_pixel,
    output logic             fb_rd,
    input  logic             sel_fb,
    input  logic             clr_underflow,
    output logic             out_vsync,
    output logic             out_req,
    output logic             out_eol,
    output logic             out_eof,
    output logic [23:0]      out_pixel,
    output logic             cur_src,
    output logic             underflow,
    output logic [CNT_W-1:0] underflow_cnt
);

    typedef enum logic [1:0] {ST_PG, ST_FB, ST_FB_UNDER} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_fb_rd;
    logic             w_under;
    logic [23:0]      w_pix_nxt;
    logic             r_vsync, r_req, r_eol, r_eof;
    logic [23:0]      r_pixel;
    logic             r_underflow;
    logic [CNT_W-1:0] r_cnt;

    // Pixel choice and pop use the pre-transition state, so a vsync cycle
    // carrying an active pixel is still served by the outgoing frame's source.
    always_comb begin
        w_state_nxt = r_state;
        w_fb_rd     = 1'b0;
        w_under     = 1'b0;
        w_pix_nxt   = '0;
        case (r_state)
            ST_PG: begin
                if (in_req) w_pix_nxt = in_pixel;
            end
            ST_FB: begin
                if (in_req) begin
                    if (fb_valid) begin
                        w_fb_rd   = 1'b1;
                        w_pix_nxt = fb_pixel;
                    end else begin
                        w_under     = 1'b1;
                        w_pix_nxt   = UNDERFLOW_COLOR;
                        w_state_nxt = ST_FB_UNDER;
                    end
                end
            end
            ST_FB_UNDER: begin
                if (in_req) w_pix_nxt = UNDERFLOW_COLOR;
            end
            default: w_state_nxt = ST_PG;
        endcase
        if (in_vsync) w_state_nxt = sel_fb ? ST_FB : ST_PG;
    end

    always_ff @(posedge vo_clk or negedge vo_reset_) begin
        if (!vo_reset_) r_state <= ST_PG;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge vo_clk or negedge vo_reset_) begin
        if (!vo_reset_) begin
            r_vsync <= 1'b0;
            r_req   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
            r_pixel <= '0;
        end else begin
            r_vsync <= in_vsync;
            r_req   <= in_req;
            r_eol   <= in_eol;
            r_eof   <= in_eof;
            r_pixel <= w_pix_nxt;
        end
    end

    // Set wins over clear; a clear coinciding with a new underflow counts it as 1.
    always_ff @(posedge vo_clk or negedge vo_reset_) begin
        if (!vo_reset_) begin
            r_underflow <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_under)            r_underflow <= 1'b1;
            else if (clr_underflow) r_underflow <= 1'b0;

            if (clr_underflow)             r_cnt <= w_under ? CNT_W'(1) : '0;
            else if (w_under && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Gate the combinational pop with reset so it drops the instant reset asserts.
    assign fb_rd         = w_fb_rd & vo_reset_;
    assign cur_src       = (r_state != ST_PG);
    assign out_vsync     = r_vsync;
    assign out_req       = r_req;
    assign out_eol       = r_eol;
    assign out_eof       = r_eof;
    assign out_pixel     = r_pixel;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_cnt;

endmodule

// File: tb/tb_vo_src_sched.sv
// Directed bench for vo_src_sched: default instance plus a CNT_W=2 instance
// on the same stimulus to exercise counter saturation.
module tb_vo_src_sched;

    logic        vo_clk = 1'b0;
    logic        vo_reset_;
    logic        in_vsync, in_req, in_eol, in_eof;
    logic [23:0] in_pixel;
    logic        fb_valid;
    logic [23:0] fb_pixel;
    logic        sel_fb, clr_underflow;

    logic        fb_rd, out_vsync, out_req, out_eol, out_eof, cur_src, underflow;
    logic [23:0] out_pixel;
    logic [7:0]  underflow_cnt;

    logic        fb_rd2, out_vsync2, out_req2, out_eol2, out_eof2, cur_src2, underflow2;
    logic [23:0] out_pixel2;
    logic [1:0]  underflow_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 vo_clk = ~vo_clk;

    vo_src_sched dut (
        .vo_clk(vo_clk), .vo_reset_(vo_reset_),
        .in_vsync(in_vsync), .in_req(in_req), .in_eol(in_eol), .in_eof(in_eof),
        .in_pixel(in_pixel), .fb_valid(fb_valid), .fb_pixel(fb_pixel), .fb_rd(fb_rd),
        .sel_fb(sel_fb), .clr_underflow(clr_underflow),
        .out_vsync(out_vsync), .out_req(out_req), .out_eol(out_eol), .out_eof(out_eof),
        .out_pixel(out_pixel), .cur_src(cur_src), .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    vo_src_sched #(.CNT_W(2)) dut2 (
        .vo_clk(vo_clk), .vo_reset_(vo_reset_),
        .in_vsync(in_vsync), .in_req(in_req), .in_eol(in_eol), .in_eof(in_eof),
        .in_pixel(in_pixel), .fb_valid(fb_valid), .fb_pixel(fb_pixel), .fb_rd(fb_rd2),
        .sel_fb(sel_fb), .clr_underflow(clr_underflow),
        .out_vsync(out_vsync2), .out_req(out_req2), .out_eol(out_eol2), .out_eof(out_eof2),
        .out_pixel(out_pixel2), .cur_src(cur_src2), .underflow(underflow2),
        .underflow_cnt(underflow_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic r, input logic eol, input logic eof,
                       input logic [23:0] pix, input logic fbv, input logic [23:0] fbp);
        in_vsync = v; in_req = r; in_eol = eol; in_eof = eof;
        in_pixel = pix; fb_valid = fbv; fb_pixel = fbp;
    endtask

    task automatic tick();
        @(posedge vo_clk);
        #1;
    endtask

    initial begin
        int pops;
        logic fbv;
        vo_reset_ = 1'b0; sel_fb = 1'b1; clr_underflow = 1'b0;
        drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h111111, 1'b1, 24'h123456);
        #1;
        // reset state
        chk("rst_fb_rd",     {31'b0, fb_rd}, 32'd0);
        chk("rst_out_pixel", {8'b0, out_pixel}, 32'd0);
        chk("rst_out_req",   {31'b0, out_req}, 32'd0);
        chk("rst_cur_src",   {31'b0, cur_src}, 32'd0);
        chk("rst_cnt",       {24'b0, underflow_cnt}, 32'd0);
        tick(); tick();
        vo_reset_ = 1'b1;

        // after release: PG until first vsync even with sel_fb=1
        drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h0000A1, 1'b1, 24'h123456);
        #1 chk("post_rst_fb_rd", {31'b0, fb_rd}, 32'd0);
        tick();
        chk("post_rst_pix", {8'b0, out_pixel}, 32'h0000A1);
        chk("post_rst_src", {31'b0, cur_src}, 32'd0);

        // pattern frame 4x2
        sel_fb = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h123456);
        tick();
        chk("pg_vsync", {31'b0, out_vsync}, 32'd1);
        chk("pg_idle_pix", {8'b0, out_pixel}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b1, (i == 3 || i == 7), (i == 7), 24'(i + 1), 1'b1, 24'h123456);
            #1 chk("pg_fb_rd", {31'b0, fb_rd}, 32'd0);
            tick();
            chk("pg_pix", {8'b0, out_pixel}, 32'(i + 1));
            chk("pg_eol", {31'b0, out_eol}, {31'b0, (i == 3 || i == 7)});
            chk("pg_src", {31'b0, cur_src}, 32'd0);
        end
        chk("pg_eof", {31'b0, out_eof}, 32'd1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 24'h00FFFF, 1'b1, 24'h123456);
        tick();
        chk("pg_blank_pix", {8'b0, out_pixel}, 32'd0);
        chk("pg_blank_req", {31'b0, out_req}, 32'd0);

        // framebuffer frame, FIFO never empty
        sel_fb = 1'b1;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h123456);
        tick();
        chk("fb_src", {31'b0, cur_src}, 32'd1);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b1, (i == 3 || i == 7), (i == 7), 24'hABCDEF, 1'b1, 24'h123456);
            #1 if (fb_rd) pops++;
            tick();
            chk("fb_pix", {8'b0, out_pixel}, 32'h123456);
        end
        chk("fb_pops", 32'(pops), 32'd8);
        chk("fb_underflow", {31'b0, underflow}, 32'd0);

        // underflow frame: FIFO empty from 3rd pixel, sel_fb dropped mid-frame
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h123456);
        tick();
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            fbv = (i < 2) || (i == 4);
            sel_fb = (i < 4);
            drv(1'b0, 1'b1, (i == 3 || i == 7), (i == 7), 24'hABCDEF, fbv, 24'h123456);
            #1 chk("uf_fb_rd", {31'b0, fb_rd}, {31'b0, (i < 2)});
            if (fb_rd) pops++;
            tick();
            chk("uf_pix", {8'b0, out_pixel}, (i < 2) ? 32'h123456 : 32'hFF00FF);
            chk("uf_src", {31'b0, cur_src}, 32'd1);
            if (i == 2) begin
                chk("uf_flag", {31'b0, underflow}, 32'd1);
                chk("uf_cnt", {24'b0, underflow_cnt}, 32'd1);
            end
        end
        chk("uf_pops", 32'(pops), 32'd2);
        chk("uf_cnt_end", {24'b0, underflow_cnt}, 32'd1);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h123456);
        tick();
        chk("sel_switch_src", {31'b0, cur_src}, 32'd0);

        // clear, then four underflow frames: saturation on the 2-bit counter
        drv(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h123456);
        clr_underflow = 1'b1;
        tick();
        clr_underflow = 1'b0;
        chk("clr_flag", {31'b0, underflow}, 32'd0);
        chk("clr_cnt",  {24'b0, underflow_cnt}, 32'd0);
        sel_fb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h123456);
            tick();
            drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h123456);
            tick();
            chk("sat_cnt2", {30'b0, underflow_cnt2}, (k < 3) ? 32'(k + 1) : 32'd3);
            chk("sat_cnt8", {24'b0, underflow_cnt}, 32'(k + 1));
        end
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h123456);
        tick();
        drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h123456);
        clr_underflow = 1'b1;
        tick();
        chk("clr_inc_cnt8", {24'b0, underflow_cnt}, 32'd1);
        chk("clr_inc_cnt2", {30'b0, underflow_cnt2}, 32'd1);
        chk("clr_inc_flag", {31'b0, underflow}, 32'd1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h123456);
        tick();
        clr_underflow = 1'b0;
        chk("clr2_flag", {31'b0, underflow}, 32'd0);
        chk("clr2_cnt",  {24'b0, underflow_cnt}, 32'd0);

        // reset mid framebuffer frame
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h123456);
        tick();
        drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b1, 24'h654321);
        tick();
        chk("mr_pix_before", {8'b0, out_pixel}, 32'h654321);
        #1 chk("mr_fb_rd_before", {31'b0, fb_rd}, 32'd1);
        vo_reset_ = 1'b0;
        #1;
        chk("mr_fb_rd", {31'b0, fb_rd}, 32'd0);
        chk("mr_pix",   {8'b0, out_pixel}, 32'd0);
        chk("mr_req",   {31'b0, out_req}, 32'd0);
        chk("mr_src",   {31'b0, cur_src}, 32'd0);
        tick();
        vo_reset_ = 1'b1;
        drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h00AA55, 1'b1, 24'h654321);
        #1 chk("mr_rel_fb_rd", {31'b0, fb_rd}, 32'd0);
        tick();
        chk("mr_rel_pix", {8'b0, out_pixel}, 32'h00AA55);
        chk("mr_rel_src", {31'b0, cur_src}, 32'd0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, 24'h654321);
        tick();
        chk("mr_vsync_src", {31'b0, cur_src}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
